pipe_stage_elastic: RTL and testbench

Parametrised elastic inter-stage register for the pipelined MIPS datapath, the successor to the fixed IF/ID latch. It carries an arbitrary-width payload (instruction, PC+4, PC+8 and later-stage control packed by the caller) between two pipeline stages with a valid/ready handshake. A two-entry skid buffer lets upstream ready be a registered signal without losing throughput. Synchronous flush and zero-fill on reset produce a nop bubble.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 23 ++
 rtl/pipe_stage_elastic.sv | 105 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined datapath stage registers.
package pipe_pkg;

  // Occupancy of an elastic stage register; the encoding doubles as the
  // entry count presented on the occupancy port.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // An all-zero payload decodes as a nop in every stage, so bubbles are
  // built by replicating this bit across the payload width.
  localparam logic PIPE_NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable and synchronous clear to the nop value.
module pipe_slot #(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear wins over load so a killed beat never lands in the slot.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: main slot M drives the output, skid slot S
// absorbs the one beat that arrives while a stall propagates upstream.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{PIPE_NOP_BIT}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_reg;
  pipe_state_t       state_next;
  logic              accept;
  logic              deliver;
  logic              m_load;
  logic              s_load;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] s_q;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // State register; reset and flush both collapse the stage to empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic from the accept/deliver handshakes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !deliver)      state_next = TWO;
        else if (!accept && deliver) state_next = EMPTY;
      end
      TWO:     if (deliver) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs decode only the state register, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    out_valid = (state_reg != EMPTY);
    in_ready  = (state_reg != TWO);
    occupancy = state_reg;
  end

  // Slot load control: M refills from the input or from S; S only catches
  // a beat accepted while M is held by a stall.
  always_comb begin
    m_load = 1'b0;
    s_load = 1'b0;
    m_d    = in_data;
    case (state_reg)
      EMPTY: m_load = accept;
      ONE: begin
        m_load = accept && deliver;
        s_load = accept && !deliver;
      end
      TWO: begin
        m_load = deliver;
        m_d    = s_q;
      end
      default: ;
    endcase
  end

  pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_slot_m (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (m_load),
    .d     (m_d),
    .q     (m_q)
  );

  pipe_slot #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_slot_s (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (s_load),
    .d     (in_data),
    .q     (s_q)
  );

  assign out_data = m_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios then random traffic,
// checked against a two-deep FIFO reference model.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 96;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  // Reference: the stage behaves as a FIFO holding at most two beats.
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_zero = 1'b1;
  bit                last_acc = 1'b0;
  bit                verbose  = 1'b1;
  int                n_pass   = 0;
  int                n_total  = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic drive(input bit r, input bit f, input bit v,
                       input logic [DATA_W-1:0] d, input bit o);
    reset     = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Reference model update at each clock edge from the bench-driven inputs.
  initial begin
    bit acc;
    bit del;
    forever begin
      @(posedge clk);
      acc = in_valid && (exp_q.size() < 2);
      del = (exp_q.size() > 0) && out_ready;
      if (reset || flush) begin
        exp_q.delete();
        exp_zero = 1'b1;
        last_acc = 1'b0;
      end else begin
        if (del) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back(in_data);
          exp_zero = 1'b0;
        end
        last_acc = acc;
      end
    end
  end

  // Monitor: mid-cycle comparison of the DUT against the reference.
  initial begin
    forever begin
      @(negedge clk);
      chk("occupancy", DATA_W'(occupancy), DATA_W'(exp_q.size()));
      chk("in_ready", DATA_W'(in_ready), DATA_W'(exp_q.size() < 2));
      chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_q.size() > 0));
      chk("ready_vs_occ", DATA_W'(in_ready), DATA_W'(occupancy != 2'd2));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (verbose && out_ready) $display("beat out data=%h occ=%0d", out_data, occupancy);
      end else if (exp_q.size() == 0 && exp_zero) begin
        chk("nop_data", out_data, '0);
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] cur_d;
    bit                cur_v;
    a = 96'h1; b = 96'h2; c = 96'h3;

    // Reset with a beat presented: nothing is captured.
    drive(1, 0, 1, 96'h1, 1);
    drive(1, 0, 1, 96'h1, 1);
    drive(0, 0, 0, '0, 1);

    // Streaming with downstream always ready.
    drive(0, 0, 1, 96'h1, 1);
    drive(0, 0, 1, 96'h2, 1);
    drive(0, 0, 1, 96'h3, 1);
    drive(0, 0, 1, 96'h4, 1);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Stall: A and B absorbed, C held upstream, then drain in order.
    drive(0, 0, 1, a, 0);
    drive(0, 0, 1, b, 0);
    drive(0, 0, 1, c, 0);
    drive(0, 0, 1, c, 0);
    drive(0, 0, 1, c, 1);
    drive(0, 0, 1, c, 1);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Flush with two entries held and a beat offered.
    drive(0, 0, 1, 96'hA, 0);
    drive(0, 0, 1, 96'hB, 0);
    drive(0, 1, 1, 96'hC, 0);
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);

    // Flush and reset together, then reset while holding one entry.
    drive(0, 0, 1, 96'h11, 0);
    drive(0, 0, 1, 96'h12, 0);
    drive(1, 1, 1, 96'h13, 0);
    drive(0, 0, 1, 96'h14, 0);
    drive(1, 0, 0, '0, 0);
    drive(0, 0, 0, '0, 1);

    // Random traffic; an offered beat is held until the model accepts it.
    verbose = 1'b0;
    cur_v = 1'b0;
    cur_d = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!(cur_v && !last_acc)) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_d = rnd_data();
      end
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 99) == 0),
            cur_v, cur_d, ($urandom_range(0, 2) != 0));
    end
    drive(0, 0, 0, '0, 1);
    drive(0, 0, 0, '0, 1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
